i2c_codec_target: RTL
=====================

Name: i2c_codec_target

Overview:
- I2C target (responder) standing in for the codec's control port; it answers the configuration writes and reads issued by the team's I2C controller.
- Decodes START/STOP, matches a 7-bit device address and keeps an auto-incrementing register pointer.
- Drives a simple synchronous register-bank bus for writes and reads.
- Used as the codec model in system benches and as the control-port front end of on-chip codec emulation.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit device address (write byte 8'h34, read byte 8'h35).
- REG_AW, 7, register pointer width; pointer wraps modulo 2^REG_AW.
- DATA_W, 8, register data width; fixed at 8 (one I2C byte).

Ports:
- clk  in  1  system clock; must be at least 16x the SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_in  in  1  raw SCL pin level (asynchronous).
- sda_in  in  1  raw SDA pin level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); top level ties the inout to 1'bz otherwise.
- reg_wr_en  out  1  one-clk pulse: write reg_wr_data at reg_addr.
- reg_addr  out  REG_AW  current register pointer; read and write address.
- reg_wr_data  out  8  write data, valid with reg_wr_en.
- reg_rd_data  in  8  bank contents at reg_addr; combinational, or registered with 1-clk latency.
- busy  out  1  high from an address ACK until STOP or a repeated START.

Behaviour:
- Reset values: sda_oe=0, reg_wr_en=0, reg_addr=0, reg_wr_data=0, busy=0, state IDLE. Asynchronous reset mid-transfer releases SDA immediately.
- Input conditioning: 2-FF synchronizer on scl_in and sda_in, plus one history flop for edge detection. Pin-to-event latency is 3 clk.
- START = synced SDA falls while SCL is high. STOP = synced SDA rises while SCL is high.
- START or STOP is recognised in every state, including mid-byte, and overrides all other activity.
- START goes to ADDR. STOP goes to IDLE. Both clear sda_oe and busy on the same clk.
- Data is sampled on SCL rising edges, MSB first. sda_oe changes only on SCL falling edges, 1 clk after detection.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- ADDR: shift 8 bits.
  - If bits[7:1]==DEV_ADDR, drive ACK (sda_oe=1) for the 9th clock and assert busy.
  - Otherwise go to WAIT with SDA never driven.
- After ADDR_ACK: R/W=0 goes to PTR; R/W=1 goes to RDATA.
- PTR: the first byte after a write address loads reg_addr. It is always ACKed. Then go to WDATA.
- WDATA: on the 8th SCL rise, latch the byte into reg_wr_data and pulse reg_wr_en for 1 clk with the current reg_addr. On the next clk, reg_addr increments with wrap. ACK every byte.
- RDATA:
  - On the SCL fall that ends the ACK, sample reg_rd_data into the shift register (a 1-clk delay is allowed for a registered bank).
  - Drive sda_oe = ~bit for each bit, then release SDA for the 9th clock.
- RDATA_ACK: sample the controller's bit on SCL rise.
  - 0 (ACK): increment reg_addr and load the next byte.
  - 1 (NACK): go to WAIT without driving SDA.
- WAIT: ignore SCL and SDA until START or STOP.
- Pointer retention: reg_addr persists across STOP and repeated START. "Write pointer, repeated START, read" therefore returns data from the written pointer.
- No clock stretching, no general call, no 10-bit addressing.

Decomposition:
- Shared package codec_pkg holds:
  - the state enum i2c_tgt_state_t;
  - CODEC_I2C_ADDR = 7'h1A (also used by the controller's instantiation);
  - ACK/NACK bit constants.
- One natural sub-module: i2c_line_sync. It contains the synchronizers and history flops and outputs scl, sda, scl_rise, scl_fall, start_det and stop_det.

Test Plan:
1. Write 8'h34, ptr 8'h12, data 8'hA5, STOP -> three ACKs; one reg_wr_en pulse with reg_addr=0x12 and data 0xA5; reg_addr ends at 0x13; busy falls at STOP.
2. Write 8'h34, ptr 8'h7F, data 8'h01, 8'h02 -> writes to 0x7F then 0x00 (wrap); all bytes ACKed.
3. Write 8'h34, ptr 8'h05, repeated START, 8'h35, read 2 bytes with ACK then NACK, STOP; bank[5]=0x3C, bank[6]=0xC3 -> SDA returns 0x3C then 0xC3; SDA released after the NACK; reg_addr=0x06.
4. Address 8'h40 followed by 3 data bytes -> sda_oe never asserted; no reg_wr_en; busy stays 0.
5. STOP injected after 4 bits of a write data byte -> no reg_wr_en; state IDLE; sda_oe=0. The next valid transaction completes normally.
6. rst_n low while the target is driving a read 0 bit -> sda_oe=0 asynchronously; all outputs return to reset values; a subsequent transaction succeeds.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared definitions for the codec control-port I2C target and its controller.
package codec_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT      = 4'd9
  } i2c_tgt_state_t;

  localparam logic [6:0] CODEC_I2C_ADDR = 7'h1A;
  localparam logic       ACK_BIT        = 1'b0;
  localparam logic       NACK_BIT       = 1'b1;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return addr_byte[7:1] == dev;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA pins and decodes clock edges and START/STOP conditions.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] first sync stage, [1] synced level, [2] history for edge detection
  logic [2:0] scl_pipe_r;
  logic [2:0] sda_pipe_r;

  // Synchronizer and history flops; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe_r <= 3'b111;
      sda_pipe_r <= 3'b111;
    end else begin
      scl_pipe_r <= {scl_pipe_r[1:0], scl_in};
      sda_pipe_r <= {sda_pipe_r[1:0], sda_in};
    end
  end

  assign scl       = scl_pipe_r[1];
  assign sda       = sda_pipe_r[1];
  assign scl_rise  =  scl_pipe_r[1] & ~scl_pipe_r[2];
  assign scl_fall  = ~scl_pipe_r[1] &  scl_pipe_r[2];
  assign start_det =  scl_pipe_r[1] &  scl_pipe_r[2] &  sda_pipe_r[2] & ~sda_pipe_r[1];
  assign stop_det  =  scl_pipe_r[1] &  scl_pipe_r[2] & ~sda_pipe_r[2] &  sda_pipe_r[1];

endmodule

// File: rtl/i2c_codec_target.sv
// I2C target for the codec control port: address match, auto-incrementing
// register pointer and a simple synchronous register-bank bus.
module i2c_codec_target
  import codec_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = CODEC_I2C_ADDR,
  parameter int         REG_AW   = 7,
  parameter int         DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              reg_wr_en,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              busy
);

  localparam logic [REG_AW-1:0] ADDR_ONE = {{(REG_AW-1){1'b0}}, 1'b1};

  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s, sample_s;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl       (scl_s),
    .sda       (sda_s),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_s),
    .stop_det  (stop_s)
  );

  assign sample_s = scl_rise_s & scl_s;

  i2c_tgt_state_t    state_r, state_nx;
  logic [3:0]        bit_cnt_r, bit_cnt_nx;
  logic [DATA_W-1:0] shift_r, shift_nx;
  logic              sda_oe_r, sda_oe_nx;
  logic              busy_r, busy_nx;
  logic [REG_AW-1:0] addr_r, addr_nx;
  logic              wr_en_r, wr_en_nx;
  logic [DATA_W-1:0] wr_data_r, wr_data_nx;
  logic              ack_seen_r, ack_seen_nx;
  logic              inc_r, inc_nx;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= {DATA_W{1'b0}};
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      addr_r     <= {REG_AW{1'b0}};
      wr_en_r    <= 1'b0;
      wr_data_r  <= {DATA_W{1'b0}};
      ack_seen_r <= 1'b0;
      inc_r      <= 1'b0;
    end else begin
      state_r    <= state_nx;
      bit_cnt_r  <= bit_cnt_nx;
      shift_r    <= shift_nx;
      sda_oe_r   <= sda_oe_nx;
      busy_r     <= busy_nx;
      addr_r     <= addr_nx;
      wr_en_r    <= wr_en_nx;
      wr_data_r  <= wr_data_nx;
      ack_seen_r <= ack_seen_nx;
      inc_r      <= inc_nx;
    end
  end

  // Next-state logic: bits shift on SCL rise, SDA drive changes on SCL fall
  always_comb begin
    state_nx    = state_r;
    bit_cnt_nx  = bit_cnt_r;
    shift_nx    = shift_r;
    sda_oe_nx   = sda_oe_r;
    busy_nx     = busy_r;
    addr_nx     = inc_r ? addr_r + ADDR_ONE : addr_r;
    wr_en_nx    = 1'b0;
    wr_data_nx  = wr_data_r;
    ack_seen_nx = ack_seen_r;
    inc_nx      = 1'b0;

    case (state_r)
      ST_ADDR, ST_PTR, ST_WDATA: begin
        if (sample_s && bit_cnt_r != 4'd8) begin
          shift_nx   = {shift_r[DATA_W-2:0], sda_s};
          bit_cnt_nx = bit_cnt_r + 4'd1;
          if (state_r == ST_WDATA && bit_cnt_r == 4'd7) begin
            wr_data_nx = {shift_r[DATA_W-2:0], sda_s};
            wr_en_nx   = 1'b1;
            inc_nx     = 1'b1;
          end else begin
            wr_en_nx = 1'b0;
          end
        end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
          if (state_r == ST_ADDR) begin
            if (addr_match(shift_r, DEV_ADDR)) begin
              state_nx  = ST_ADDR_ACK;
              sda_oe_nx = ~ACK_BIT;
              busy_nx   = 1'b1;
            end else begin
              state_nx = ST_WAIT;
            end
          end else if (state_r == ST_PTR) begin
            addr_nx   = shift_r[REG_AW-1:0];
            sda_oe_nx = ~ACK_BIT;
            state_nx  = ST_PTR_ACK;
          end else begin
            sda_oe_nx = ~ACK_BIT;
            state_nx  = ST_WDATA_ACK;
          end
        end else begin
          bit_cnt_nx = bit_cnt_r;
        end
      end
      ST_ADDR_ACK: begin
        if (scl_fall_s) begin
          bit_cnt_nx = 4'd0;
          if (shift_r[0]) begin
            state_nx  = ST_RDATA;
            shift_nx  = reg_rd_data;
            sda_oe_nx = ~reg_rd_data[DATA_W-1];
          end else begin
            state_nx  = ST_PTR;
            sda_oe_nx = 1'b0;
          end
        end else begin
          bit_cnt_nx = bit_cnt_r;
        end
      end
      ST_PTR_ACK, ST_WDATA_ACK: begin
        if (scl_fall_s) begin
          sda_oe_nx  = 1'b0;
          bit_cnt_nx = 4'd0;
          state_nx   = ST_WDATA;
        end else begin
          bit_cnt_nx = bit_cnt_r;
        end
      end
      ST_RDATA: begin
        if (sample_s) begin
          bit_cnt_nx = bit_cnt_r + 4'd1;
        end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
          sda_oe_nx   = 1'b0;
          ack_seen_nx = 1'b0;
          state_nx    = ST_RDATA_ACK;
        end else if (scl_fall_s && bit_cnt_r != 4'd0) begin
          shift_nx  = {shift_r[DATA_W-2:0], 1'b0};
          sda_oe_nx = ~shift_r[DATA_W-2];
        end else begin
          bit_cnt_nx = bit_cnt_r;
        end
      end
      ST_RDATA_ACK: begin
        if (sample_s) begin
          if (sda_s == ACK_BIT) begin
            ack_seen_nx = 1'b1;
            addr_nx     = addr_r + ADDR_ONE;
          end else begin
            state_nx = ST_WAIT;
          end
        end else if (scl_fall_s && ack_seen_r) begin
          shift_nx    = reg_rd_data;
          sda_oe_nx   = ~reg_rd_data[DATA_W-1];
          bit_cnt_nx  = 4'd0;
          ack_seen_nx = 1'b0;
          state_nx    = ST_RDATA;
        end else begin
          bit_cnt_nx = bit_cnt_r;
        end
      end
      ST_IDLE, ST_WAIT: begin
        state_nx = state_r;
      end
      default: begin
        state_nx  = ST_IDLE;
        sda_oe_nx = 1'b0;
        busy_nx   = 1'b0;
      end
    endcase

    // Bus conditions override everything; the pointer is retained
    if (start_s || stop_s) begin
      state_nx    = start_s ? ST_ADDR : ST_IDLE;
      bit_cnt_nx  = 4'd0;
      sda_oe_nx   = 1'b0;
      busy_nx     = 1'b0;
      wr_en_nx    = 1'b0;
      inc_nx      = 1'b0;
      ack_seen_nx = 1'b0;
    end else begin
      ack_seen_nx = ack_seen_nx;
    end
  end

  assign sda_oe      = sda_oe_r;
  assign busy        = busy_r;
  assign reg_addr    = addr_r;
  assign reg_wr_en   = wr_en_r;
  assign reg_wr_data = wr_data_r;

endmodule
